// File: rtl/ctrl_pkt_arbiter_pkg.sv
// Shared UDT control-path definitions: packet type codes, requester indices,
// default datapath width and arbiter FSM encoding.
package ctrl_pkt_arbiter_pkg;

    localparam int DATA_W_DEF = 64;

    localparam logic [14:0] PKT_KEEPALIVE = 15'd1;
    localparam logic [14:0] PKT_ACK       = 15'd2;
    localparam logic [14:0] PKT_NAK       = 15'd3;
    localparam logic [14:0] PKT_SHUTDOWN  = 15'd5;
    localparam logic [14:0] PKT_ACK2      = 15'd6;

    localparam int REQ_ACK2      = 0;
    localparam int REQ_ACK       = 1;
    localparam int REQ_NAK       = 2;
    localparam int REQ_KEEPALIVE = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ctrl_pkt_arbiter_axis_reg_slice.sv
// axis_reg_slice: 2-entry AXI-stream skid buffer (tdata/tkeep/tlast) with fully
// registered outputs and an input ready that depends only on local state.
module axis_reg_slice #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last
);

    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [KEEP_W-1:0] out_keep_r;
    logic              out_last_r;
    logic              skid_valid_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [KEEP_W-1:0] skid_keep_r;
    logic              skid_last_r;

    assign in_ready  = ~skid_valid_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_keep  = out_keep_r;
    assign out_last  = out_last_r;

    // Main/skid register pair; skid absorbs the beat accepted while the output stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            out_keep_r   <= {KEEP_W{1'b0}};
            out_last_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DATA_W{1'b0}};
            skid_keep_r  <= {KEEP_W{1'b0}};
            skid_last_r  <= 1'b0;
        end else if (!out_valid_r || out_ready) begin
            if (skid_valid_r) begin
                out_valid_r  <= 1'b1;
                out_data_r   <= skid_data_r;
                out_keep_r   <= skid_keep_r;
                out_last_r   <= skid_last_r;
                skid_valid_r <= 1'b0;
            end else if (in_valid) begin
                out_valid_r <= 1'b1;
                out_data_r  <= in_data;
                out_keep_r  <= in_keep;
                out_last_r  <= in_last;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (in_valid && !skid_valid_r) begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= in_data;
            skid_keep_r  <= in_keep;
            skid_last_r  <= in_last;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

endmodule

// File: rtl/ctrl_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing the UDT control-packet stream.
// Define CTRL_ARB_ACK2_PRIO_EN to give requester 0 (ACK2) absolute priority.
module ctrl_pkt_arbiter
    import ctrl_pkt_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      core_clk,
    input  logic                      core_rst,
    input  logic [NUM_REQ*DATA_W-1:0] req_tdata,
    input  logic [NUM_REQ*KEEP_W-1:0] req_tkeep,
    input  logic [NUM_REQ-1:0]        req_tvalid,
    output logic [NUM_REQ-1:0]        req_tready,
    input  logic [NUM_REQ-1:0]        req_tlast,
    output logic [DATA_W-1:0]         ctrl_tdata,
    output logic [KEEP_W-1:0]         ctrl_tkeep,
    output logic                      ctrl_tvalid,
    input  logic                      ctrl_tready,
    output logic                      ctrl_tlast,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    arb_state_e          state_r;
    arb_state_e          state_nxt_s;
    logic [IDX_W-1:0]    grant_id_r;
    logic [IDX_W-1:0]    rr_ptr_r;
    logic [IDX_W-1:0]    pick_idx_s;
    logic [IDX_W-1:0]    cand_s;
    logic                pick_found_s;
    logic                pick_hit_s;
    logic                pick_upd_rr_s;
    logic [NUM_REQ-1:0]  req_tready_s;
    logic [DATA_W-1:0]   req_data_a [NUM_REQ];
    logic [KEEP_W-1:0]   req_keep_a [NUM_REQ];
    logic                slice_in_valid_s;
    logic                slice_in_ready_s;
    logic                beat_acc_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_data_a[g] = req_tdata[g*DATA_W +: DATA_W];
        assign req_keep_a[g] = req_tkeep[g*KEEP_W +: KEEP_W];
    end

    assign slice_in_valid_s = (state_r == ST_BUSY) & req_tvalid[grant_id_r];
    assign beat_acc_s       = slice_in_valid_s & slice_in_ready_s;
    assign req_tready       = req_tready_s;
    assign grant_id         = grant_id_r;
    assign busy             = (state_r == ST_BUSY);

    // Cyclic search starting after the round-robin pointer; the last winner ranks lowest.
    always_comb begin
        pick_found_s  = 1'b0;
        pick_hit_s    = 1'b0;
        pick_idx_s    = grant_id_r;
        pick_upd_rr_s = 1'b1;
        cand_s        = {IDX_W{1'b0}};
`ifdef CTRL_ARB_ACK2_PRIO_EN
        if (req_tvalid[REQ_ACK2]) begin
            pick_found_s  = 1'b1;
            pick_idx_s    = IDX_W'(REQ_ACK2);
            pick_upd_rr_s = 1'b0;
        end else begin
            pick_upd_rr_s = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s       = IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            pick_hit_s   = !pick_found_s && req_tvalid[cand_s];
            pick_idx_s   = pick_hit_s ? cand_s : pick_idx_s;
            pick_found_s = pick_found_s | pick_hit_s;
        end
    end

    // Next-state and per-requester ready decode.
    always_comb begin
        state_nxt_s  = state_r;
        req_tready_s = {NUM_REQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                req_tready_s[grant_id_r] = slice_in_ready_s;
                if (beat_acc_s && req_tlast[grant_id_r]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_r    <= ST_IDLE;
            grant_id_r <= IDX_W'(NUM_REQ - 1);
            rr_ptr_r   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && pick_found_s) begin
                grant_id_r <= pick_idx_s;
                if (pick_upd_rr_s) begin
                    rr_ptr_r <= pick_idx_s;
                end else begin
                    rr_ptr_r <= rr_ptr_r;
                end
            end else begin
                grant_id_r <= grant_id_r;
            end
        end
    end

    axis_reg_slice #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_slice (
        .clk       (core_clk),
        .rst       (core_rst),
        .in_valid  (slice_in_valid_s),
        .in_ready  (slice_in_ready_s),
        .in_data   (req_data_a[grant_id_r]),
        .in_keep   (req_keep_a[grant_id_r]),
        .in_last   (req_tlast[grant_id_r]),
        .out_valid (ctrl_tvalid),
        .out_ready (ctrl_tready),
        .out_data  (ctrl_tdata),
        .out_keep  (ctrl_tkeep),
        .out_last  (ctrl_tlast)
    );

endmodule

// File: tb/tb_ctrl_pkt_arbiter.sv
// Scoreboard bench for ctrl_pkt_arbiter: per-requester beat tables drive the
// inputs, expected output beats are queued up front and popped on each ctrl handshake.
module tb_ctrl_pkt_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int KEEP_W  = 8;
    localparam int IDX_W   = 2;
    localparam int MAXB    = 16;

    logic                      core_clk = 1'b0;
    logic                      core_rst = 1'b1;
    logic [NUM_REQ*DATA_W-1:0] req_tdata = '0;
    logic [NUM_REQ*KEEP_W-1:0] req_tkeep = '0;
    logic [NUM_REQ-1:0]        req_tvalid = '0;
    logic [NUM_REQ-1:0]        req_tready;
    logic [NUM_REQ-1:0]        req_tlast = '0;
    logic [DATA_W-1:0]         ctrl_tdata;
    logic [KEEP_W-1:0]         ctrl_tkeep;
    logic                      ctrl_tvalid;
    logic                      ctrl_tready = 1'b1;
    logic                      ctrl_tlast;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;

    ctrl_pkt_arbiter dut (
        .core_clk    (core_clk),
        .core_rst    (core_rst),
        .req_tdata   (req_tdata),
        .req_tkeep   (req_tkeep),
        .req_tvalid  (req_tvalid),
        .req_tready  (req_tready),
        .req_tlast   (req_tlast),
        .ctrl_tdata  (ctrl_tdata),
        .ctrl_tkeep  (ctrl_tkeep),
        .ctrl_tvalid (ctrl_tvalid),
        .ctrl_tready (ctrl_tready),
        .ctrl_tlast  (ctrl_tlast),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 core_clk = ~core_clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [IDX_W-1:0]  id;
    } beat_t;

    beat_t       sb_q[$];
    int          grant_log[$];
    logic [DATA_W-1:0] src_data [NUM_REQ][MAXB];
    logic [KEEP_W-1:0] src_keep [NUM_REQ][MAXB];
    logic        src_last [NUM_REQ][MAXB];
    int          src_len [NUM_REQ];
    int          src_pos [NUM_REQ];
    int          hold_at [NUM_REQ];
    int          hold_left [NUM_REQ];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tready_mode = 0;
    logic        prev_busy = 1'b0;
    logic        stall_prev = 1'b0;
    beat_t       stall_beat;
    logic        saw_rdy_drop = 1'b0;
    logic        gap_en = 1'b0;
    logic        gap_armed = 1'b0;
    int          low_run = 0;
    int          rises = 0;

    task automatic clear_sources();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_len[i] = 0; src_pos[i] = 0; hold_at[i] = 0; hold_left[i] = 0;
        end
        sb_q.delete();
        grant_log.delete();
        stall_prev = 1'b0;
    endtask

    task automatic add_beat(input int r, input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k, input logic l);
        src_data[r][src_len[r]] = d;
        src_keep[r][src_len[r]] = k;
        src_last[r][src_len[r]] = l;
        src_len[r]++;
    endtask

    task automatic add_pkt(input int r, input int n, input logic [DATA_W-1:0] base);
        for (int b = 0; b < n; b++) add_beat(r, base + DATA_W'(b), 8'hFF, (b == n - 1));
    endtask

    task automatic expect_pkt(input int r, input int first, input int n);
        beat_t e;
        for (int b = first; b < first + n; b++) begin
            e.data = src_data[r][b]; e.keep = src_keep[r][b];
            e.last = src_last[r][b]; e.id = IDX_W'(r);
            sb_q.push_back(e);
        end
    endtask

    // One clock: drive at the falling edge, then evaluate what the next rising edge will transfer.
    task automatic tick();
        beat_t e;
        logic  hold;
        @(negedge core_clk);
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            hold = (hold_left[i] > 0) && (src_pos[i] == hold_at[i]);
            if (hold) hold_left[i]--;
            req_tvalid[i] = (src_pos[i] < src_len[i]) && !hold;
            req_tdata[i*DATA_W +: DATA_W] = (src_pos[i] < src_len[i]) ? src_data[i][src_pos[i]] : '0;
            req_tkeep[i*KEEP_W +: KEEP_W] = (src_pos[i] < src_len[i]) ? src_keep[i][src_pos[i]] : '0;
            req_tlast[i] = (src_pos[i] < src_len[i]) ? src_last[i][src_pos[i]] : 1'b0;
        end
        ctrl_tready = (tready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
        #1;
        if (core_rst) begin
            prev_busy = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!ctrl_tvalid || ctrl_tdata !== stall_beat.data || ctrl_tkeep !== stall_beat.keep
                    || ctrl_tlast !== stall_beat.last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%h k=%h l=%0b required d=%h k=%h l=%0b",
                             ctrl_tvalid, ctrl_tdata, ctrl_tkeep, ctrl_tlast,
                             stall_beat.data, stall_beat.keep, stall_beat.last);
                end
            end
            stall_prev = ctrl_tvalid && !ctrl_tready;
            stall_beat.data = ctrl_tdata; stall_beat.keep = ctrl_tkeep;
            stall_beat.last = ctrl_tlast; stall_beat.id = grant_id;
            if (ctrl_tvalid && ctrl_tready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got d=%h required no beat", ctrl_tdata);
                end else begin
                    e = sb_q.pop_front();
                    if (ctrl_tdata !== e.data || ctrl_tkeep !== e.keep || ctrl_tlast !== e.last || grant_id !== e.id) begin
                        errors++;
                        $display("FAIL beat: got d=%h k=%h l=%0b id=%0d required d=%h k=%h l=%0b id=%0d",
                                 ctrl_tdata, ctrl_tkeep, ctrl_tlast, grant_id, e.data, e.keep, e.last, e.id);
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_tvalid[i] && req_tready[i]) begin
                    src_pos[i]++;
                    checks++;
                    if (i != int'(grant_id) || !busy) begin
                        errors++;
                        $display("FAIL ready_owner: got ready on req %0d busy=%0b required grant %0d", i, busy, grant_id);
                    end
                end
            end
            if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
            prev_busy = busy;
            if (busy && tready_mode == 1 && req_tready == 4'b0000) saw_rdy_drop = 1'b1;
            if (!ctrl_tvalid) begin
                low_run++;
            end else begin
                if (low_run > 0 && gap_en) begin
                    rises++;
                    if (gap_armed) begin
                        checks++;
                        if (low_run != 1) begin
                            errors++;
                            $display("FAIL pkt_gap: got %0d idle cycles required 1", low_run);
                        end
                    end
                    gap_armed = 1'b1;
                end
                low_run = 0;
            end
        end
    endtask

    task automatic apply_reset();
        core_rst = 1'b1;
        clear_sources();
        tick(); tick();
        core_rst = 1'b0;
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            done = (sb_q.size() == 0) && !busy && !ctrl_tvalid;
            for (int i = 0; i < NUM_REQ; i++) if (src_pos[i] != src_len[i]) done = 1'b0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats pending required 0 within budget", name, sb_q.size());
        end
    endtask

    task automatic check_grants(input string name, input int exp_q[$]);
        checks++;
        if (grant_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_grant_count: got %0d required %0d", name, grant_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[j]) begin
                checks++;
                if (grant_log[j] != exp_q[j]) begin
                    errors++;
                    $display("FAIL %s_grant%0d: got %0d required %0d", name, j, grant_log[j], exp_q[j]);
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (ctrl_tvalid !== 1'b0 || ctrl_tdata !== 64'h0 || ctrl_tkeep !== 8'h00 || ctrl_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got v=%0b d=%h k=%h l=%0b required all zero", ctrl_tvalid, ctrl_tdata, ctrl_tkeep, ctrl_tlast);
        end
        checks++;
        if (req_tready !== 4'b0000 || grant_id !== 2'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_arb: got rdy=%b gid=%0d busy=%0b required 0000 3 0", req_tready, grant_id, busy);
        end
    endtask

    task automatic test_single();
        int lat;
        apply_reset();
        add_beat(2, 64'h11, 8'hFF, 1'b0);
        add_beat(2, 64'h22, 8'hFF, 1'b0);
        add_beat(2, 64'h33, 8'h0F, 1'b1);
        expect_pkt(2, 0, 3);
        lat = -1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 0) begin
                checks++;
                if (req_tready !== 4'b0000 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_idle: got rdy=%b busy=%0b required 0000 0", req_tready, busy);
                end
            end
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1 || grant_id !== 2'd2) begin
                    errors++;
                    $display("FAIL single_grant: got busy=%0b gid=%0d required 1 2", busy, grant_id);
                end
            end
            if (ctrl_tvalid && lat < 0) lat = c;
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL single_latency: got %0d required 2", lat);
        end
        drain("single");
    endtask

    task automatic test_round_robin();
        int exp_q[$];
        apply_reset();
        add_pkt(0, 2, 64'hA000);
        add_pkt(0, 2, 64'hA010);
        add_pkt(1, 2, 64'hB000);
        add_pkt(2, 2, 64'hC000);
        add_pkt(3, 2, 64'hD000);
`ifdef CTRL_ARB_ACK2_PRIO_EN
        expect_pkt(0, 0, 2); expect_pkt(0, 2, 2); expect_pkt(1, 0, 2);
        expect_pkt(2, 0, 2); expect_pkt(3, 0, 2);
        exp_q = '{0, 0, 1, 2, 3};
`else
        expect_pkt(0, 0, 2); expect_pkt(1, 0, 2); expect_pkt(2, 0, 2);
        expect_pkt(3, 0, 2); expect_pkt(0, 2, 2);
        exp_q = '{0, 1, 2, 3, 0};
`endif
        gap_en = 1'b1; gap_armed = 1'b0; low_run = 0; rises = 0;
        drain("rr");
        gap_en = 1'b0;
        check_grants("rr", exp_q);
        checks++;
        if (rises != 5) begin
            errors++;
            $display("FAIL rr_contiguous: got %0d valid bursts required 5", rises);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        add_beat(1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
        add_beat(1, 64'hFEDC_BA98_7654_3210, 8'hF0, 1'b0);
        add_beat(1, 64'h5555_AAAA_5555_AAAA, 8'h3C, 1'b0);
        add_beat(1, 64'hDEAD_BEEF_0000_0001, 8'h01, 1'b1);
        expect_pkt(1, 0, 4);
        saw_rdy_drop = 1'b0;
        tready_mode = 1;
        drain("bp");
        tready_mode = 0;
        checks++;
        if (!saw_rdy_drop) begin
            errors++;
            $display("FAIL bp_ready_drop: got no req_tready deassertion while busy required one");
        end
    endtask

    task automatic test_mid_stall();
        int held;
        int exp_q[$];
        apply_reset();
        add_pkt(1, 4, 64'h1100);
        add_pkt(3, 2, 64'h3300);
        hold_at[1] = 1; hold_left[1] = 5;
        expect_pkt(1, 0, 4); expect_pkt(3, 0, 2);
        held = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (src_pos[1] == 1 && !req_tvalid[1]) begin
                held++;
                checks++;
                if (busy !== 1'b1 || grant_id !== 2'd1 || req_tready[3] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_lock: got busy=%0b gid=%0d rdy3=%0b required 1 1 0", busy, grant_id, req_tready[3]);
                end
            end
        end
        checks++;
        if (held != 5) begin
            errors++;
            $display("FAIL stall_len: got %0d held cycles required 5", held);
        end
        drain("stall");
        exp_q = '{1, 3};
        check_grants("stall", exp_q);
    endtask

    task automatic test_reset_mid();
        int exp_q[$];
        apply_reset();
        add_pkt(2, 4, 64'h2200);
        expect_pkt(2, 0, 4);
        for (int c = 0; c < 20 && src_pos[2] < 2; c++) tick();
        core_rst = 1'b1;
        clear_sources();
        tick();
        checks++;
        if (ctrl_tvalid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd3 || ctrl_tlast !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got v=%0b busy=%0b gid=%0d l=%0b required 0 0 3 0", ctrl_tvalid, busy, grant_id, ctrl_tlast);
        end
        core_rst = 1'b0;
        add_pkt(0, 2, 64'h9900);
        expect_pkt(0, 0, 2);
        drain("rst_mid");
        exp_q = '{0};
        check_grants("rst_mid", exp_q);
    endtask

`ifdef CTRL_ARB_ACK2_PRIO_EN
    task automatic test_ack2_prio();
        int exp_q[$];
        apply_reset();
        add_pkt(1, 4, 64'h4100);
        expect_pkt(1, 0, 4);
        for (int c = 0; c < 20 && !busy; c++) tick();
        add_pkt(3, 2, 64'h4300);
        add_pkt(0, 2, 64'h4000);
        expect_pkt(0, 0, 2); expect_pkt(3, 0, 2);
        drain("prio");
        exp_q = '{1, 0, 3};
        check_grants("prio", exp_q);
    endtask
`endif

    initial begin
        clear_sources();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mid_stall();
        test_reset_mid();
`ifdef CTRL_ARB_ACK2_PRIO_EN
        test_ack2_prio();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ctrl_pkt_arbiter.md
Name: ctrl_pkt_arbiter

Overview:
- Shares the single outbound UDT control-packet AXI-stream (64-bit, to the UDP/packet-send path) between NUM_REQ control-packet generators (ACK, ACK2, NAK, keep-alive/shutdown).
- Packet-granular round-robin arbitration. Once a requester is granted, its packet is forwarded beat-for-beat until tlast; other requesters never interleave.
- Registered output (reg slice); full throughput inside a packet.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 = ACK2, 1 = ACK, 2 = NAK, 3 = keep-alive/shutdown.
- DATA_W, 64, tdata width; tkeep width is DATA_W/8.

Ports:
- core_clk  in  1  core module clock.
- core_rst  in  1  synchronous, active-high reset.
- req_tdata  in  NUM_REQ*DATA_W  requester tdata; requester i occupies bits [i*DATA_W +: DATA_W].
- req_tkeep  in  NUM_REQ*DATA_W/8  requester byte enables, same packing.
- req_tvalid  in  NUM_REQ  per-requester valid.
- req_tready  out  NUM_REQ  per-requester ready.
- req_tlast  in  NUM_REQ  per-requester end of packet.
- ctrl_tdata  out  DATA_W  arbitrated control packet data.
- ctrl_tkeep  out  DATA_W/8  arbitrated byte enables.
- ctrl_tvalid  out  1  output valid.
- ctrl_tready  in  1  downstream ready.
- ctrl_tlast  out  1  output end of packet.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high while a packet is in progress (state BUSY).

Behaviour:
- Reset values:
  - ctrl_tvalid=0, ctrl_tdata=0, ctrl_tkeep=0, ctrl_tlast=0.
  - req_tready=0, grant_id=NUM_REQ-1, so the first grant search starts at requester 0.
  - busy=0, state=IDLE.
- IDLE state:
  - If any req_tvalid is high, pick the first valid index searching cyclically from grant_id+1 (wrapping at NUM_REQ).
  - Register the pick into grant_id and go to BUSY on the next cycle.
  - req_tready stays 0 in IDLE.
- BUSY state:
  - req_tready[grant_id] equals the slice input-ready. All other req_tready bits are 0.
  - Each accepted beat (req_tvalid & req_tready of the granted requester) is captured by the output slice.
  - When the accepted beat has tlast=1, return to IDLE on the next cycle; grant_id is held.
  - Consequence: one bubble cycle between packets, so minimum packet-to-packet gap on ctrl_* is 1 cycle.
- Output slice:
  - 2-entry skid buffer; latency 1 cycle from the input handshake to ctrl_tvalid.
  - Sustains 1 beat/cycle under continuous ctrl_tready.
  - ctrl_* must be held stable while ctrl_tvalid=1 and ctrl_tready=0.
  - The slice drains independently of the arbiter state.
- Granted requester drops tvalid mid-packet: stay in BUSY and wait. No timeout.
- Simultaneous events:
  - Last-beat acceptance and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - A requester that just finished has the lowest priority in the next arbitration.
- tkeep is passed through unchanged; no checking or repacking.
- Synchronous reset mid-packet: the packet is abandoned (output truncated, no tlast emitted) and all state returns to reset values. Upper layers tolerate this because reset also clears the generators.

Optional Feature:
- Macro: CTRL_ARB_ACK2_PRIO_EN.
- Defined: requester 0 (ACK2) has absolute priority in IDLE and wins over any other valid requester, keeping RTT samples tight. Round-robin among requesters 1..NUM_REQ-1 is unchanged; requester 0 grants do not update the round-robin pointer. Packet locking still applies, so ACK2 waits for the in-flight packet's tlast.
- Undefined: pure round-robin over all NUM_REQ requesters, as described above.

Decomposition:
- Shared package/include (udt_defs):
  - control packet type codes (ACK=2, NAK=3, ACK2=6, keep-alive=1, shutdown=5).
  - requester index constants (REQ_ACK2=0, REQ_ACK=1, REQ_NAK=2, REQ_KEEPALIVE=3).
  - DATA_W default.
  - localparam for FSM encoding IDLE=0, BUSY=1.
- One sub-module: axis_reg_slice (2-entry skid buffer for tdata/tkeep/tlast), reusable elsewhere on the UDT datapath.

Test Plan:
- Single requester: req 2 sends a 3-beat packet (data 0x11,0x22,0x33; tkeep FF,FF,0F), ctrl_tready=1 → ctrl_* carries identical beats starting 2 cycles after tvalid rises; tlast only on 0x33; grant_id=2.
- Round-robin fairness: all four requesters hold 2-beat packets → grant order 0,1,2,3,0; each packet contiguous; 1-cycle gap between packets.
- Backpressure: ctrl_tready toggles 1/0 every cycle during a 4-beat packet → no beat lost or duplicated; ctrl_* stable while stalled; req_tready deasserts within the slice capacity.
- Mid-packet stall: granted req 1 drops tvalid for 5 cycles after beat 1 while req 3 is valid → req 3 is not granted; req 1 completes first, then req 3.
- Reset mid-packet: assert core_rst at beat 2 of 4 → next cycle ctrl_tvalid=0, busy=0, grant_id=NUM_REQ-1; a fresh request afterward goes through normally.
- With CTRL_ARB_ACK2_PRIO_EN: reqs 0,1,3 all valid and req 1 currently busy → after req 1's tlast the next grant is 0, then 3.
